// File: rtl/sram_burst_reader.sv
// rtl/sram_burst_reader.sv - Avalon-MM burst read master with FWFT output FIFO
// Optional response watchdog enabled by defining SRAM_READER_TIMEOUT_EN.
module sram_burst_reader #(
    parameter int ADDR_WIDTH      = 20,
    parameter int DATA_WIDTH      = 16,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int LEN_WIDTH       = 16,
    parameter int FIFO_AW         = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic [BE_WIDTH-1:0]   m_byteenable,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_WIDTH-1:0] m_writedata,
    input  logic                  m_waitrequest,
    input  logic [DATA_WIDTH-1:0] m_readdata,
    input  logic                  m_readdataready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  timeout
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam logic [CW-1:0] MAX_PEND = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  remaining_nxt;
    logic [CW-1:0]         pending;
    logic [CW-1:0]         pending_nxt;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         count_nxt;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  aborting;
    logic                  accept;
    logic                  resp;
    logic                  pop;
    logic                  push;
    logic                  flush;
    logic                  credit;
    logic                  tmo_hit;

    assign m_byteenable = '1;
    assign m_write      = 1'b0;
    assign m_writedata  = '0;
    assign out_valid    = (fifo_count != '0);
    assign out_data     = out_valid ? mem[rd_ptr] : '0;

    // Credit is judged on next-cycle occupancy so a registered m_read can never
    // over-commit the FIFO, even while a request is held by waitrequest.
    always_comb begin
        accept        = m_read && !m_waitrequest;
        resp          = m_readdataready && (pending != '0);
        pop           = out_valid && out_ready;
        flush         = (state != IDLE) && (abort || tmo_hit);
        push          = resp && !aborting && !flush;
        remaining_nxt = accept ? remaining - LEN_WIDTH'(1) : remaining;
        pending_nxt   = pending + CW'(accept) - CW'(resp);
        if (tmo_hit) begin
            pending_nxt = '0;
        end
        count_nxt = fifo_count + CW'(push) - CW'(pop);
        if (flush) begin
            count_nxt = '0;
        end
        credit = (pending_nxt < MAX_PEND) &&
                 (({1'b0, pending_nxt} + {1'b0, count_nxt}) < DEPTH_C);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            m_address <= '0;
            remaining <= '0;
            pending   <= '0;
            m_read    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborting  <= 1'b0;
        end else begin
            done    <= 1'b0;
            pending <= pending_nxt;
            if (accept) begin
                m_address <= m_address + ADDR_WIDTH'(1);
                remaining <= remaining_nxt;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            m_address <= base_addr;
                            remaining <= length;
                            busy      <= 1'b1;
                            aborting  <= 1'b0;
                            m_read    <= credit;
                        end
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state    <= DRAIN;
                        aborting <= 1'b1;
                        m_read   <= 1'b0;
                    end else if (remaining_nxt == '0) begin
                        state  <= DRAIN;
                        m_read <= 1'b0;
                    end else begin
                        m_read <= credit;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        aborting <= 1'b1;
                    end
                    if (pending_nxt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= !aborting && !flush;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            fifo_count <= count_nxt;
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + FIFO_AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + FIFO_AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= m_readdata;
        end
    end

`ifdef SRAM_READER_TIMEOUT_EN
    logic [11:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == 12'hFFF);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (m_readdataready || (pending == '0) || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 12'd1;
            end
            if ((state == IDLE) && start) begin
                timeout <= 1'b0;
            end else if (tmo_hit) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule
